// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the uart transmit feeder.
// Holds the feeder FSM encoding and the uart byte width.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        FEED_IDLE,
        FEED_LAUNCH,
        FEED_BUSY
    } feed_state_e;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: producer stream plus uart transmit port.
// slave is the feeder side, master is the producer/uart side.
interface uart_tx_feeder_if;
    import uart_pkg::*;

    logic [UART_BYTE_W-1:0] s_data;
    logic                   s_valid;
    logic                   s_ready;
    logic                   uart_transmit;
    logic [UART_BYTE_W-1:0] uart_tx_byte;
    logic                   uart_tx_free;

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output uart_transmit,
        output uart_tx_byte,
        input  uart_tx_free
    );

    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  uart_transmit,
        input  uart_tx_byte,
        output uart_tx_free
    );

endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: single-clock byte FIFO with wrap-bit pointers.
// Read data is the head entry, consumed by the pop at the clock edge.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [UART_BYTE_W-1:0] i_data,
    input  logic                   i_pop,
    output logic [UART_BYTE_W-1:0] o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [DEPTH_LOG2:0]    o_level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [UART_BYTE_W-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2:0]    r_wr_ptr;
    logic [DEPTH_LOG2:0]    r_rd_ptr;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_lo_eq;

    assign w_lo_eq = r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0];
    assign o_full  = w_lo_eq && (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);
    assign o_empty = r_wr_ptr == r_rd_ptr;
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_data  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // storage needs no reset: pointers define what is valid
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers a byte stream and feeds the uart transmitter.
// Define UART_TX_CTS_EN to add a synchronised active-low cts_n gate.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_feeder_if.slave     bus,
    output logic [DEPTH_LOG2:0] level,
    output logic                idle
`ifdef UART_TX_CTS_EN
    ,
    input  logic                cts_n
`endif
);

    localparam logic [DEPTH_LOG2:0] LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    feed_state_e            r_state;
    feed_state_e            w_next;
    logic                   r_ready;
    logic                   r_transmit;
    logic                   r_guard;
    logic [UART_BYTE_W-1:0] r_tx_byte;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_gate;
    logic                   w_full;
    logic                   w_empty;
    logic [UART_BYTE_W-1:0] w_head;
    logic [DEPTH_LOG2:0]    w_level_next;

    assign w_push = bus.s_valid && r_ready && !w_full;

    uart_byte_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_push),
        .i_data (bus.s_data),
        .i_pop  (w_pop),
        .o_data (w_head),
        .o_full (w_full),
        .o_empty(w_empty),
        .o_level(level)
    );

`ifdef UART_TX_CTS_EN
    logic [1:0] r_cts_sync;

    // resets to blocked so nothing leaves before the peer is seen ready
    always_ff @(posedge clk) begin
        if (rst) r_cts_sync <= 2'b11;
        else     r_cts_sync <= {r_cts_sync[0], cts_n};
    end

    assign w_gate = !r_cts_sync[1];
`else
    assign w_gate = 1'b1;
`endif

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        unique case (r_state)
            FEED_IDLE: begin
                if (!w_empty && bus.uart_tx_free && w_gate) begin
                    w_pop  = 1'b1;
                    w_next = FEED_LAUNCH;
                end
            end
            FEED_LAUNCH: w_next = FEED_BUSY;
            FEED_BUSY: begin
                if (!r_guard && bus.uart_tx_free) w_next = FEED_IDLE;
            end
            default: w_next = FEED_IDLE;
        endcase
    end

    assign w_level_next = level
                        + {{DEPTH_LOG2{1'b0}}, w_push}
                        - {{DEPTH_LOG2{1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FEED_IDLE;
            r_ready    <= 1'b1;
            r_transmit <= 1'b0;
            r_guard    <= 1'b0;
            r_tx_byte  <= '0;
        end else begin
            r_state    <= w_next;
            r_ready    <= w_level_next != LVL_FULL;
            r_transmit <= w_next == FEED_LAUNCH;
            // first BUSY cycle may still see the stale tx_free high
            r_guard    <= r_state == FEED_LAUNCH;
            if (w_pop) r_tx_byte <= w_head;
        end
    end

    assign bus.s_ready       = r_ready;
    assign bus.uart_transmit = r_transmit;
    assign bus.uart_tx_byte  = r_tx_byte;
    assign idle              = w_empty && (r_state == FEED_IDLE);

endmodule
